// File: rtl/cpu_defs.sv
// cpu_defs: shared CPU definitions.
// Holds CP0 register addresses ({rd, sel}), ExcCode values, the default
// exception vector and the exception-sequencer FSM state encoding.
package cpu_defs;

  // CP0 register addresses as {rd[4:0], sel[2:0]}
  localparam logic [7:0] CR_COUNT   = {5'd9,  3'd0};
  localparam logic [7:0] CR_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] CR_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] CR_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] CR_EPC     = {5'd14, 3'd0};

  // ExcCode values written to Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } excp_state_e;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: CP0 Count/Compare timer.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   tmr_we, tmr_sel, tmr_wdata MTC0 write (sel 0 = Count, 1 = Compare)
//   count_rdata, compare_rdata current Count / Compare for MFC0
//   ti                         timer interrupt flag (Cause.TI)
module cp0_timer
  import cpu_defs::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tmr_we,
  input  logic        tmr_sel,
  input  logic [31:0] tmr_wdata,
  output logic [31:0] count_rdata,
  output logic [31:0] compare_rdata,
  output logic        ti
);

  // With COUNT_DIV == 1 the single prescaler bit stays at 0, so every cycle wraps.
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_reg;
  logic [31:0]   count_reg;
  logic [31:0]   compare_reg;
  logic          ti_reg;

  logic        wrap;
  logic        count_we;
  logic        compare_we;
  logic [31:0] count_inc;

  assign wrap       = (presc_reg == PRESC_MAX);
  assign count_we   = tmr_we & ~tmr_sel;
  assign compare_we = tmr_we & tmr_sel;
  assign count_inc  = count_reg + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg   <= '0;
      count_reg   <= '0;
      compare_reg <= '0;
      ti_reg      <= 1'b0;
    end else begin
      if (count_we) begin
        count_reg <= tmr_wdata;
        presc_reg <= '0;
      end else begin
        presc_reg <= wrap ? '0 : presc_reg + 1'b1;
        if (wrap) count_reg <= count_inc;
      end

      // A Compare write beats a same-cycle match; only a real increment can match.
      if (compare_we) begin
        compare_reg <= tmr_wdata;
        ti_reg      <= 1'b0;
      end else if (!count_we && wrap && (count_inc == compare_reg)) begin
        ti_reg <= 1'b1;
      end
    end
  end

  assign count_rdata   = count_reg;
  assign compare_rdata = compare_reg;
  assign ti            = ti_reg;

endmodule

// File: rtl/excp_ctrl.sv
// excp_ctrl: exception/interrupt sequencer between WB and cp0.
// Picks one committing event from WB (interrupt > exception > ERET), pulses
// the cp0 strobes, flushes the pipe for two cycles and then holds a fetch
// redirect (to EXC_VECTOR or EPC) until fetch accepts it.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   ws_*                                WB instruction fields
//   cp0_status_*, cp0_sw_ip, cp0_EPC    CP0 state
//   ext_int_in                          asynchronous hardware interrupt lines
//   tmr_we, tmr_sel, tmr_wdata          MTC0 to Count/Compare
//   fs_redirect_ready                   fetch accepts the redirect
//   ws_to_cp0_valid, commit_*           exception commit to cp0
//   eret_flush                          ERET commit to cp0
//   flush, redirect_valid, redirect_pc  pipeline kill and fetch redirect
//   cause_ip, cause_ti                  Cause.IP / Cause.TI
//   count_rdata, compare_rdata          MFC0 read data
module excp_ctrl
  import cpu_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic        ws_excp,
  input  logic [4:0]  ws_excp_execode,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic        ws_eret,
  input  logic        cp0_status_IE,
  input  logic        cp0_status_EXL,
  input  logic [7:0]  cp0_status_IM,
  input  logic [1:0]  cp0_sw_ip,
  input  logic [31:0] cp0_EPC,
  input  logic [4:0]  ext_int_in,
  input  logic        tmr_we,
  input  logic        tmr_sel,
  input  logic [31:0] tmr_wdata,
  input  logic        fs_redirect_ready,
  output logic        ws_to_cp0_valid,
  output logic [4:0]  commit_execode,
  output logic [31:0] commit_pc,
  output logic        commit_bd,
  output logic        eret_flush,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [7:0]  cause_ip,
  output logic        cause_ti,
  output logic [31:0] count_rdata,
  output logic [31:0] compare_rdata
);

  excp_state_e state_reg;
  logic        redirect_valid_reg;
  logic [31:0] redirect_pc_reg;
  logic [4:0]  int_sync1_reg;
  logic [4:0]  int_sync2_reg;

  logic in_idle;
  logic int_req;
  logic take_int;
  logic take_excp;
  logic take_eret;
  logic take_any;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .tmr_we        (tmr_we),
    .tmr_sel       (tmr_sel),
    .tmr_wdata     (tmr_wdata),
    .count_rdata   (count_rdata),
    .compare_rdata (compare_rdata),
    .ti            (cause_ti)
  );

  // Two-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge clk) begin
    if (reset) begin
      int_sync1_reg <= '0;
      int_sync2_reg <= '0;
    end else begin
      int_sync1_reg <= ext_int_in;
      int_sync2_reg <= int_sync1_reg;
    end
  end

  assign cause_ip = {cause_ti, int_sync2_reg, cp0_sw_ip};
  assign int_req  = cp0_status_IE & ~cp0_status_EXL & (|(cause_ip & cp0_status_IM)) & ws_valid;

  // WB is only sampled in IDLE; the strobes are also suppressed while in reset.
  assign in_idle   = (state_reg == ST_IDLE) & ~reset;
  assign take_int  = in_idle & int_req;
  assign take_excp = in_idle & ~int_req & ws_valid & ws_excp;
  assign take_eret = in_idle & ~int_req & ws_valid & ~ws_excp & ws_eret;
  assign take_any  = take_int | take_excp | take_eret;

  assign ws_to_cp0_valid = take_int | take_excp;
  assign eret_flush      = take_eret;
  assign commit_execode  = take_int ? EXC_INT : ws_excp_execode;
  assign commit_pc       = ws_pc;
  assign commit_bd       = ws_bd;

  assign flush          = take_any | ((state_reg == ST_FLUSH) & ~reset);
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (take_any) begin
            state_reg       <= ST_FLUSH;
            // EPC is captured in the commit cycle; cp0 may rewrite it afterwards.
            redirect_pc_reg <= take_eret ? cp0_EPC : EXC_VECTOR;
          end
        end
        ST_FLUSH: begin
          state_reg          <= ST_REDIR;
          redirect_valid_reg <= 1'b1;
        end
        ST_REDIR: begin
          if (fs_redirect_ready) begin
            state_reg          <= ST_IDLE;
            redirect_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg          <= ST_IDLE;
          redirect_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_excp_ctrl.sv
// tb_excp_ctrl: directed self-checking bench for excp_ctrl.
// Expected commits are queued when the event is driven and popped when the
// DUT strobes ws_to_cp0_valid / eret_flush; the expected redirect target is
// checked when redirect_valid rises.
module tb_excp_ctrl;

  localparam logic [31:0] VEC = 32'hbfc00380;

  typedef struct {
    logic [1:0]  kind;    // {eret_flush, ws_to_cp0_valid}
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] target;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ws_valid, ws_excp, ws_bd, ws_eret;
  logic [4:0]  ws_excp_execode;
  logic [31:0] ws_pc;
  logic        cp0_status_IE, cp0_status_EXL;
  logic [7:0]  cp0_status_IM;
  logic [1:0]  cp0_sw_ip;
  logic [31:0] cp0_EPC;
  logic [4:0]  ext_int_in;
  logic        tmr_we, tmr_sel;
  logic [31:0] tmr_wdata;
  logic        fs_redirect_ready;
  logic        ws_to_cp0_valid;
  logic [4:0]  commit_execode;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        eret_flush, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [7:0]  cause_ip;
  logic        cause_ti;
  logic [31:0] count_rdata, compare_rdata;

  int   vectors;
  int   miscompares;
  exp_t sb[$];
  exp_t cur;
  logic [31:0] cur_target;
  logic rv_prev;

  excp_ctrl #(
    .EXC_VECTOR (VEC),
    .COUNT_DIV  (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ws_valid          (ws_valid),
    .ws_excp           (ws_excp),
    .ws_excp_execode   (ws_excp_execode),
    .ws_pc             (ws_pc),
    .ws_bd             (ws_bd),
    .ws_eret           (ws_eret),
    .cp0_status_IE     (cp0_status_IE),
    .cp0_status_EXL    (cp0_status_EXL),
    .cp0_status_IM     (cp0_status_IM),
    .cp0_sw_ip         (cp0_sw_ip),
    .cp0_EPC           (cp0_EPC),
    .ext_int_in        (ext_int_in),
    .tmr_we            (tmr_we),
    .tmr_sel           (tmr_sel),
    .tmr_wdata         (tmr_wdata),
    .fs_redirect_ready (fs_redirect_ready),
    .ws_to_cp0_valid   (ws_to_cp0_valid),
    .commit_execode    (commit_execode),
    .commit_pc         (commit_pc),
    .commit_bd         (commit_bd),
    .eret_flush        (eret_flush),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .cause_ip          (cause_ip),
    .cause_ti          (cause_ti),
    .count_rdata       (count_rdata),
    .compare_rdata     (compare_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: runs at the falling edge, away from the active edge.
  task automatic monitor();
    if (ws_to_cp0_valid || eret_flush) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_commit", {30'd0, eret_flush, ws_to_cp0_valid}, 32'd0);
      end else begin
        cur = sb.pop_front();
        chk("sb_kind", {30'd0, eret_flush, ws_to_cp0_valid}, {30'd0, cur.kind});
        if (cur.kind == 2'b01) begin
          chk("sb_execode", {27'd0, commit_execode}, {27'd0, cur.code});
          chk("sb_pc", commit_pc, cur.pc);
          chk("sb_bd", {31'd0, commit_bd}, {31'd0, cur.bd});
        end
        cur_target = cur.target;
        $display("commit kind=%b code=%h pc=%h bd=%b", {eret_flush, ws_to_cp0_valid},
                 commit_execode, commit_pc, commit_bd);
      end
    end
    if (redirect_valid && !rv_prev) begin
      chk("sb_redirect_pc", redirect_pc, cur_target);
      $display("redirect pc=%h", redirect_pc);
    end
    rv_prev = redirect_valid;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] kind, input logic [4:0] code, input logic [31:0] pc,
                      input logic bd, input logic [31:0] target);
    exp_t e;
    e.kind = kind; e.code = code; e.pc = pc; e.bd = bd; e.target = target;
    sb.push_back(e);
  endtask

  // Called in the commit cycle N (after its checks). WB inputs stay asserted
  // through FLUSH/REDIR so any second commit is caught; cleared on the accept cycle.
  task automatic event_tail(input int wait_cycles, input logic [31:0] exp_pc);
    tick();                                   // N+1: FLUSH
    cp0_EPC = 32'hdeadbeef;
    #1;
    chk("flush_n1", {31'd0, flush}, 32'd1);
    chk("rv_n1", {31'd0, redirect_valid}, 32'd0);
    chk("no_strobe_n1", {30'd0, eret_flush, ws_to_cp0_valid}, 32'd0);
    tick();                                   // N+2: REDIR
    for (int i = 0; i < wait_cycles; i++) begin
      chk("flush_redir", {31'd0, flush}, 32'd0);
      chk("rv_hold", {31'd0, redirect_valid}, 32'd1);
      chk("rpc_hold", redirect_pc, exp_pc);
      tick();
    end
    fs_redirect_ready = 1'b1;
    ws_valid = 1'b0; ws_excp = 1'b0; ws_eret = 1'b0;
    #1;
    chk("rv_accept", {31'd0, redirect_valid}, 32'd1);
    chk("rpc_accept", redirect_pc, exp_pc);
    tick();
    fs_redirect_ready = 1'b0;
    #1;
    chk("rv_drop", {31'd0, redirect_valid}, 32'd0);
    chk("flush_idle", {31'd0, flush}, 32'd0);
    chk("rpc_idle_hold", redirect_pc, exp_pc);
  endtask

  task automatic tmr_write(input logic sel, input logic [31:0] data);
    tmr_we = 1'b1; tmr_sel = sel; tmr_wdata = data;
    tick();
    tmr_we = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; rv_prev = 1'b0; cur_target = '0;
    reset = 1'b1;
    ws_valid = 0; ws_excp = 0; ws_excp_execode = '0; ws_pc = '0; ws_bd = 0; ws_eret = 0;
    cp0_status_IE = 0; cp0_status_EXL = 0; cp0_status_IM = '0; cp0_sw_ip = '0;
    cp0_EPC = '0; ext_int_in = '0; tmr_we = 0; tmr_sel = 0; tmr_wdata = '0;
    fs_redirect_ready = 0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_cp0_valid", {31'd0, ws_to_cp0_valid}, 32'd0);
    chk("rst_eret", {31'd0, eret_flush}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_count", count_rdata, 32'd0);
    chk("rst_compare", compare_rdata, 32'd0);
    chk("rst_ti", {31'd0, cause_ti}, 32'd0);
    chk("rst_cause_ip", {24'd0, cause_ip}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: syscall exception, ready after 2 REDIR cycles
    ws_valid = 1; ws_excp = 1; ws_excp_execode = 5'h08; ws_pc = 32'hbfc00100; ws_bd = 0;
    push(2'b01, 5'h08, 32'hbfc00100, 1'b0, VEC);
    #1;
    chk("exc_strobe", {31'd0, ws_to_cp0_valid}, 32'd1);
    chk("exc_flush_n", {31'd0, flush}, 32'd1);
    event_tail(2, VEC);
    tick();

    // 2: ERET, ready held low 3 REDIR cycles
    ws_valid = 1; ws_eret = 1; ws_pc = 32'hbfc00400; cp0_EPC = 32'hbfc01234;
    push(2'b10, 5'h00, 32'hbfc00400, 1'b0, 32'hbfc01234);
    #1;
    chk("eret_strobe", {31'd0, eret_flush}, 32'd1);
    chk("eret_no_exc", {31'd0, ws_to_cp0_valid}, 32'd0);
    event_tail(3, 32'hbfc01234);
    tick();

    // 3: timer interrupt via Count/Compare
    cp0_status_IE = 1; cp0_status_EXL = 0; cp0_status_IM = 8'h80;
    tmr_write(1'b1, 32'd10);
    tmr_write(1'b0, 32'd0);                   // edge W
    #1;
    chk("tmr_count_w", count_rdata, 32'd0);
    for (int i = 0; i < 19; i++) tick();
    chk("tmr_ti_early", {31'd0, cause_ti}, 32'd0);
    chk("tmr_count_19", count_rdata, 32'd9);
    tick();
    chk("tmr_ti_set", {31'd0, cause_ti}, 32'd1);
    chk("tmr_count_20", count_rdata, 32'd10);
    chk("tmr_ip7", {31'd0, cause_ip[7]}, 32'd1);
    ws_valid = 1; ws_pc = 32'hbfc00200; ws_bd = 1;
    push(2'b01, 5'h00, 32'hbfc00200, 1'b1, VEC);
    #1;
    chk("tmr_int_strobe", {31'd0, ws_to_cp0_valid}, 32'd1);
    chk("tmr_int_code", {27'd0, commit_execode}, 32'd0);
    event_tail(0, VEC);
    ws_bd = 0;
    tmr_write(1'b1, 32'd1000);
    #1;
    chk("tmr_ti_clear", {31'd0, cause_ti}, 32'd0);
    chk("tmr_compare", compare_rdata, 32'd1000);
    cp0_status_IM = 8'h00;
    tick();

    // 4: external interrupt beats a same-instruction exception
    cp0_status_IM = 8'h04; ext_int_in = 5'b00001;
    #1;
    chk("ext_ip_0", {31'd0, cause_ip[2]}, 32'd0);
    tick();
    chk("ext_ip_1", {31'd0, cause_ip[2]}, 32'd0);
    tick();
    chk("ext_ip_2", {31'd0, cause_ip[2]}, 32'd1);
    ws_valid = 1; ws_excp = 1; ws_excp_execode = 5'h0a; ws_pc = 32'hbfc00300;
    push(2'b01, 5'h00, 32'hbfc00300, 1'b0, VEC);
    #1;
    chk("ext_int_code", {27'd0, commit_execode}, 32'd0);
    ws_eret = 1;                              // a further event during FLUSH/REDIR
    event_tail(2, VEC);
    ext_int_in = '0; cp0_status_IM = 8'h00;
    tick(); tick(); tick();

    // 5: Count wraparound against Compare=0, then Compare write wins
    tmr_write(1'b1, 32'd0);
    tmr_write(1'b0, 32'hffffffff);            // edge W
    #1;
    chk("wrap_count_w", count_rdata, 32'hffffffff);
    tick();
    chk("wrap_count_w1", count_rdata, 32'hffffffff);
    chk("wrap_ti_w1", {31'd0, cause_ti}, 32'd0);
    tick();
    chk("wrap_count_w2", count_rdata, 32'd0);
    chk("wrap_ti_w2", {31'd0, cause_ti}, 32'd1);
    tmr_write(1'b1, 32'd5);
    chk("cmp5_ti_clear", {31'd0, cause_ti}, 32'd0);
    tmr_write(1'b0, 32'd3);                   // edge W'
    tick(); tick(); tick();                   // W'+3, count 4
    chk("race_count_4", count_rdata, 32'd4);
    tmr_write(1'b1, 32'd5);                   // W'+4: increment to 5 collides with write
    chk("race_count_5", count_rdata, 32'd5);
    chk("race_ti", {31'd0, cause_ti}, 32'd0);

    // 6: reset while in REDIR
    cp0_status_IE = 0;
    ws_valid = 1; ws_excp = 1; ws_excp_execode = 5'h0c; ws_pc = 32'hbfc00500;
    push(2'b01, 5'h0c, 32'hbfc00500, 1'b0, VEC);
    #1;
    chk("rr_strobe", {31'd0, ws_to_cp0_valid}, 32'd1);
    tick();
    ws_valid = 0; ws_excp = 0;
    tick();
    chk("rr_in_redir", {31'd0, redirect_valid}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rr_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rr_flush", {31'd0, flush}, 32'd0);
    chk("rr_rpc", redirect_pc, 32'd0);
    reset = 1'b0;
    tick();
    chk("rr_idle_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rr_idle_flush", {31'd0, flush}, 32'd0);
    tick();

    chk("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/excp_ctrl.md
# excp_ctrl

Exception/interrupt sequencer between the writeback stage and `cp0`. It owns the Count/Compare timer and interrupt-pending logic. It picks the single event (interrupt, instruction exception, ERET) that commits from WB, pulses the CP0 update strobes, flushes all stages and redirects fetch to the exception vector or to EPC. It is the only block that drives `ws_to_cp0_valid` and `eret_flush`.

## Interface
Parameters:
- `EXC_VECTOR`, 32'hbfc00380, redirect target for every exception/interrupt
- `COUNT_DIV`, 2, clk cycles per Count increment (power of 2, ≥1)

Ports (one clock; reset is synchronous, active-high):
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high
- `ws_valid`  in  1  valid instruction in WB this cycle
- `ws_excp`  in  1  WB instruction carries an exception
- `ws_excp_execode`  in  5  ExcCode for `ws_excp`
- `ws_pc`  in  32  WB instruction PC
- `ws_bd`  in  1  WB instruction is in a delay slot
- `ws_eret`  in  1  WB instruction is ERET
- `cp0_status_IE`, `cp0_status_EXL`  in  1 each  from `cp0_general_bus`
- `cp0_status_IM`  in  8  interrupt mask
- `cp0_sw_ip`  in  2  Cause.IP[1:0] software bits
- `cp0_EPC`  in  32  from `cp0_EPC_bus`
- `ext_int_in`  in  5  async hardware interrupt lines
- `tmr_we`  in  1  MTC0 to Count/Compare
- `tmr_sel`  in  1  0=Count, 1=Compare
- `tmr_wdata`  in  32  MTC0 data
- `fs_redirect_ready`  in  1  fetch accepts redirect
- `ws_to_cp0_valid`  out  1  exception commit strobe to `cp0`
- `commit_execode`  out  5  ExcCode for `cp0`
- `commit_pc`, `commit_bd`  out  32/1  PC and BD for `cp0`
- `eret_flush`  out  1  ERET commit strobe
- `flush`  out  1  kill all stage valids
- `redirect_valid`  out  1  fetch redirect request
- `redirect_pc`  out  32  redirect target
- `cause_ip`  out  8  {TI, hw[4:0], sw[1:0]} for Cause.IP
- `cause_ti`  out  1  timer interrupt flag
- `count_rdata`, `compare_rdata`  out  32 each  MFC0 read data

## Operation
- `ext_int_in` passes through a 2-flop synchronizer before `cause_ip[6:2]`.
- `int_req = cp0_status_IE & ~cp0_status_EXL & |(cause_ip & cp0_status_IM) & ws_valid`.
- Event priority in IDLE: interrupt (execode 5'h00) > `ws_excp` > `ws_eret`. Only the winner commits. Lower-priority events on the same instruction are dropped.
- Exception/interrupt: `ws_to_cp0_valid`=1, `commit_*` = WB fields, target = `EXC_VECTOR`.
- ERET: `eret_flush`=1, target = `cp0_EPC` sampled that cycle.
- FSM IDLE → FLUSH on any event. FLUSH → REDIR unconditionally. REDIR → IDLE when `fs_redirect_ready`.
- In FLUSH/REDIR all WB inputs are ignored; no second commit.
- Timer: prescaler counts to `COUNT_DIV`-1 and wraps; Count increments on wrap, 32-bit wraparound.
- Count write loads `tmr_wdata` and clears the prescaler.
- Compare write loads Compare and clears TI.
- TI sets when an increment produces Count==Compare. TI stays set until a Compare write. A Compare write wins over a same-cycle set.

## Timing
- Reset: state IDLE. Outputs are 0: `ws_to_cp0_valid`, `eret_flush`, `flush`, `redirect_valid`, `redirect_pc`, Count, Compare, TI, prescaler, synchronizer flops.
- Cycle N, an event is seen in IDLE:
  - `ws_to_cp0_valid`/`eret_flush` pulse for exactly one cycle (combinational), so `cp0` updates at the end of N.
  - `flush`=1 in N (combinational) and in N+1 (FLUSH).
- `redirect_valid`=1 from N+2 (REDIR), held with `redirect_pc` stable until the cycle `fs_redirect_ready`=1. It drops the next cycle.
- `redirect_pc` is registered at N and holds its last value in IDLE.
- Interrupt latency: external edge to `cause_ip` is 2 cycles, plus 1 cycle to commit on the next valid WB instruction.
- `reset` asserted in any state forces IDLE the next cycle and drops all strobes. No partial redirect survives.

## Structure
- Shared package `cpu_defs`:
  - CR address constants (`CR_COUNT`, `CR_COMPARE`, `CR_STATUS`, `CR_CAUSE`, `CR_EPC`)
  - ExcCode constants (`EXC_INT`, `EXC_SYS`, …)
  - `EXC_VECTOR` default
  - FSM state encoding
- One sub-module: `cp0_timer` (prescaler, Count, Compare, TI). `excp_ctrl` holds the synchronizer, priority and FSM.

## Test plan
- ws_valid, ws_excp=1, execode 5'h08, pc 32'hbfc00100, bd=0 → one-cycle ws_to_cp0_valid; flush for 2 cycles; redirect_pc 32'hbfc00380 held until ready.
- ws_eret=1 with cp0_EPC=32'hbfc01234, fs_redirect_ready low for 3 cycles → eret_flush one pulse; redirect_valid stays 1 with stable pc for 4 cycles.
- IE=1, EXL=0, IM[7]=1, Compare=10, Count write 0 → TI sets after 20 cycles. Next valid WB commits execode 0. Compare write clears TI.
- ext_int_in[0] raised, IM[2]=1, while ws_excp=1 (execode 5'h0a) → interrupt wins, execode 0. A second event arriving in REDIR is ignored.
- Count write 32'hffffffff → wraps to 0 after COUNT_DIV cycles; Count==Compare=0 sets TI.
- reset asserted during REDIR → next cycle redirect_valid=0, flush=0, state IDLE.
